// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch and
// the LSU with a single-outstanding-transaction FSM. The LSU has fixed
// priority. Fetch responses made stale by a taken jump are dropped.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating stall-cycle counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_i_req,
  input  logic [ADDR_W-1:0]   fetch_i_addr,
  input  logic                fetch_i_flush,
  output logic [DATA_W-1:0]   fetch_o_rdata,
  output logic                fetch_o_valid,
  input  logic                lsu_i_req,
  input  logic                lsu_i_we,
  input  logic [ADDR_W-1:0]   lsu_i_addr,
  input  logic [DATA_W-1:0]   lsu_i_wdata,
  input  logic [DATA_W/8-1:0] lsu_i_wstrb,
  output logic [DATA_W-1:0]   lsu_o_rdata,
  output logic                lsu_o_valid,
  output logic                bus_o_req,
  output logic                bus_o_we,
  output logic [ADDR_W-1:0]   bus_o_addr,
  output logic [DATA_W-1:0]   bus_o_wdata,
  output logic [DATA_W/8-1:0] bus_o_wstrb,
  input  logic                bus_i_gnt,
  input  logic                bus_i_rvalid,
  input  logic [DATA_W-1:0]   bus_i_rdata,
  output logic                ctrl_o_regF_stall,
  output logic                ctrl_o_regM_stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_o_if_stall_cycles,
  output logic [31:0]         perf_o_lsu_stall_cycles
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_LSU  = 3'd1,
    WAIT_LSU = 3'd2,
    REQ_IF   = 3'd3,
    WAIT_IF  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                discard_q, discard_d;
  logic                bus_req_d;
  logic                bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_d;
  logic [DATA_W-1:0]   fetch_rdata_d;
  logic                fetch_valid_d;
  logic [DATA_W-1:0]   lsu_rdata_d;
  logic                lsu_valid_d;

  // A request is pending until its response pulse; this also keeps IDLE from
  // re-issuing a request in the cycle its response is delivered.
  assign ctrl_o_regF_stall = fetch_i_req && !fetch_o_valid;
  assign ctrl_o_regM_stall = lsu_i_req && !lsu_o_valid;

  // Next-state and next-output logic; bus fields hold unless a request is latched.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    bus_req_d     = bus_o_req;
    bus_we_d      = bus_o_we;
    bus_addr_d    = bus_o_addr;
    bus_wdata_d   = bus_o_wdata;
    bus_wstrb_d   = bus_o_wstrb;
    fetch_rdata_d = fetch_o_rdata;
    fetch_valid_d = 1'b0;
    lsu_rdata_d   = lsu_o_rdata;
    lsu_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (ctrl_o_regM_stall) begin
          state_d     = REQ_LSU;
          bus_req_d   = 1'b1;
          bus_we_d    = lsu_i_we;
          bus_addr_d  = lsu_i_addr;
          bus_wdata_d = lsu_i_we ? lsu_i_wdata : '0;
          bus_wstrb_d = lsu_i_we ? lsu_i_wstrb : '1;
        end else if (ctrl_o_regF_stall && !fetch_i_flush) begin
          state_d     = REQ_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = fetch_i_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '1;
        end
      end

      REQ_LSU: begin
        if (bus_i_gnt) begin
          bus_req_d = 1'b0;
          state_d   = WAIT_LSU;
        end
      end

      WAIT_LSU: begin
        if (bus_i_rvalid) begin
          lsu_rdata_d = bus_i_rdata;
          lsu_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end

      REQ_IF: begin
        if (bus_i_gnt) begin
          bus_req_d = 1'b0;
          state_d   = WAIT_IF;
          discard_d = fetch_i_flush;
        end else if (fetch_i_flush) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      WAIT_IF: begin
        if (bus_i_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!discard_q && !fetch_i_flush) begin
            fetch_rdata_d = bus_i_rdata;
            fetch_valid_d = 1'b1;
          end
        end else if (fetch_i_flush) begin
          discard_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      discard_q     <= 1'b0;
      bus_o_req     <= 1'b0;
      bus_o_we      <= 1'b0;
      bus_o_addr    <= '0;
      bus_o_wdata   <= '0;
      bus_o_wstrb   <= '0;
      fetch_o_rdata <= '0;
      fetch_o_valid <= 1'b0;
      lsu_o_rdata   <= '0;
      lsu_o_valid   <= 1'b0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      bus_o_req     <= bus_req_d;
      bus_o_we      <= bus_we_d;
      bus_o_addr    <= bus_addr_d;
      bus_o_wdata   <= bus_wdata_d;
      bus_o_wstrb   <= bus_wstrb_d;
      fetch_o_rdata <= fetch_rdata_d;
      fetch_o_valid <= fetch_valid_d;
      lsu_o_rdata   <= lsu_rdata_d;
      lsu_o_valid   <= lsu_valid_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating counts of cycles each stall output is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_o_if_stall_cycles  <= 32'd0;
      perf_o_lsu_stall_cycles <= 32'd0;
    end else begin
      if (ctrl_o_regF_stall && (perf_o_if_stall_cycles != 32'hFFFF_FFFF))
        perf_o_if_stall_cycles <= perf_o_if_stall_cycles + 32'd1;
      if (ctrl_o_regM_stall && (perf_o_lsu_stall_cycles != 32'hFFFF_FFFF))
        perf_o_lsu_stall_cycles <= perf_o_lsu_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fetch_i_req;
  logic [63:0] fetch_i_addr;
  logic        fetch_i_flush;
  logic [63:0] fetch_o_rdata;
  logic        fetch_o_valid;
  logic        lsu_i_req;
  logic        lsu_i_we;
  logic [63:0] lsu_i_addr;
  logic [63:0] lsu_i_wdata;
  logic [7:0]  lsu_i_wstrb;
  logic [63:0] lsu_o_rdata;
  logic        lsu_o_valid;
  logic        bus_o_req;
  logic        bus_o_we;
  logic [63:0] bus_o_addr;
  logic [63:0] bus_o_wdata;
  logic [7:0]  bus_o_wstrb;
  logic        bus_i_gnt;
  logic        bus_i_rvalid;
  logic [63:0] bus_i_rdata;
  logic        ctrl_o_regF_stall;
  logic        ctrl_o_regM_stall;

  int tests_run;
  int tests_failed;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_i_req       (fetch_i_req),
    .fetch_i_addr      (fetch_i_addr),
    .fetch_i_flush     (fetch_i_flush),
    .fetch_o_rdata     (fetch_o_rdata),
    .fetch_o_valid     (fetch_o_valid),
    .lsu_i_req         (lsu_i_req),
    .lsu_i_we          (lsu_i_we),
    .lsu_i_addr        (lsu_i_addr),
    .lsu_i_wdata       (lsu_i_wdata),
    .lsu_i_wstrb       (lsu_i_wstrb),
    .lsu_o_rdata       (lsu_o_rdata),
    .lsu_o_valid       (lsu_o_valid),
    .bus_o_req         (bus_o_req),
    .bus_o_we          (bus_o_we),
    .bus_o_addr        (bus_o_addr),
    .bus_o_wdata       (bus_o_wdata),
    .bus_o_wstrb       (bus_o_wstrb),
    .bus_i_gnt         (bus_i_gnt),
    .bus_i_rvalid      (bus_i_rvalid),
    .bus_i_rdata       (bus_i_rdata),
    .ctrl_o_regF_stall (ctrl_o_regF_stall),
    .ctrl_o_regM_stall (ctrl_o_regM_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    fetch_i_req   = 1'b0;
    fetch_i_addr  = 64'h0;
    fetch_i_flush = 1'b0;
    lsu_i_req     = 1'b0;
    lsu_i_we      = 1'b0;
    lsu_i_addr    = 64'h0;
    lsu_i_wdata   = 64'h0;
    lsu_i_wstrb   = 8'h0;
    bus_i_gnt     = 1'b0;
    bus_i_rvalid  = 1'b0;
    bus_i_rdata   = 64'h0;

    // Reset state
    step();
    chk("rst_bus_req", bus_o_req, 64'd0);
    chk("rst_bus_wstrb", bus_o_wstrb, 64'd0);
    chk("rst_fetch_valid", fetch_o_valid, 64'd0);
    chk("rst_lsu_valid", lsu_o_valid, 64'd0);
    rst_n = 1'b1;
    step();

    // Single fetch, immediate gnt, rvalid next cycle
    fetch_i_req  = 1'b1;
    fetch_i_addr = 64'h1000;
    #1;
    chk("f1_c0_stall", ctrl_o_regF_stall, 64'd1);
    chk("f1_c0_req", bus_o_req, 64'd0);
    step();
    chk("f1_c1_req", bus_o_req, 64'd1);
    chk("f1_c1_addr", bus_o_addr, 64'h1000);
    chk("f1_c1_we", bus_o_we, 64'd0);
    chk("f1_c1_wstrb", bus_o_wstrb, 64'hFF);
    chk("f1_c1_stall", ctrl_o_regF_stall, 64'd1);
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt = 1'b0;
    chk("f1_c2_req", bus_o_req, 64'd0);
    chk("f1_c2_stall", ctrl_o_regF_stall, 64'd1);
    chk("f1_c2_valid", fetch_o_valid, 64'd0);
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'h13;
    step();
    bus_i_rvalid = 1'b0;
    chk("f1_c3_valid", fetch_o_valid, 64'd1);
    chk("f1_c3_rdata", fetch_o_rdata, 64'h13);
    chk("f1_c3_stall", ctrl_o_regF_stall, 64'd0);
    fetch_i_req = 1'b0;
    step();
    chk("f1_c4_valid", fetch_o_valid, 64'd0);
    chk("f1_c4_req", bus_o_req, 64'd0);

    // Simultaneous fetch and LSU load: LSU first
    fetch_i_req  = 1'b1;
    fetch_i_addr = 64'h1000;
    lsu_i_req    = 1'b1;
    lsu_i_we     = 1'b0;
    lsu_i_addr   = 64'h2000;
    step();
    chk("pr_c1_req", bus_o_req, 64'd1);
    chk("pr_c1_addr", bus_o_addr, 64'h2000);
    chk("pr_c1_we", bus_o_we, 64'd0);
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt    = 1'b0;
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'hAAAA;
    chk("pr_c2_req", bus_o_req, 64'd0);
    step();
    bus_i_rvalid = 1'b0;
    chk("pr_c3_lvalid", lsu_o_valid, 64'd1);
    chk("pr_c3_lrdata", lsu_o_rdata, 64'hAAAA);
    chk("pr_c3_fvalid", fetch_o_valid, 64'd0);
    chk("pr_c3_req", bus_o_req, 64'd0);
    chk("pr_c3_mstall", ctrl_o_regM_stall, 64'd0);
    chk("pr_c3_fstall", ctrl_o_regF_stall, 64'd1);
    lsu_i_req = 1'b0;
    step();
    chk("pr_c4_req", bus_o_req, 64'd1);
    chk("pr_c4_addr", bus_o_addr, 64'h1000);
    chk("pr_c4_lvalid", lsu_o_valid, 64'd0);
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt    = 1'b0;
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'h55;
    step();
    bus_i_rvalid = 1'b0;
    chk("pr_c6_fvalid", fetch_o_valid, 64'd1);
    chk("pr_c6_frdata", fetch_o_rdata, 64'h55);
    fetch_i_req = 1'b0;
    step();

    // LSU store with gnt delayed 4 cycles
    lsu_i_req   = 1'b1;
    lsu_i_we    = 1'b1;
    lsu_i_addr  = 64'h3000;
    lsu_i_wdata = 64'hDEAD;
    lsu_i_wstrb = 8'h0F;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("st_req", bus_o_req, 64'd1);
      chk("st_addr", bus_o_addr, 64'h3000);
      chk("st_we", bus_o_we, 64'd1);
      chk("st_wdata", bus_o_wdata, 64'hDEAD);
      chk("st_wstrb", bus_o_wstrb, 64'h0F);
      if (i == 4) bus_i_gnt = 1'b1;
      step();
    end
    bus_i_gnt = 1'b0;
    chk("st_req_drop", bus_o_req, 64'd0);
    chk("st_no_valid_yet", lsu_o_valid, 64'd0);
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'h0;
    step();
    bus_i_rvalid = 1'b0;
    chk("st_ack_valid", lsu_o_valid, 64'd1);
    lsu_i_req = 1'b0;
    lsu_i_we  = 1'b0;
    step();

    // Flush while waiting for fetch response, then a new fetch to 0x4000
    fetch_i_req  = 1'b1;
    fetch_i_addr = 64'h1100;
    step();
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt     = 1'b0;
    fetch_i_flush = 1'b1;
    step();
    fetch_i_flush = 1'b0;
    fetch_i_addr  = 64'h4000;
    chk("fl_c3_valid", fetch_o_valid, 64'd0);
    step();
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'hBAD;
    step();
    bus_i_rvalid = 1'b0;
    chk("fl_drop_valid", fetch_o_valid, 64'd0);
    chk("fl_drop_stall", ctrl_o_regF_stall, 64'd1);
    chk("fl_drop_req", bus_o_req, 64'd0);
    step();
    chk("fl_new_req", bus_o_req, 64'd1);
    chk("fl_new_addr", bus_o_addr, 64'h4000);
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt    = 1'b0;
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'h4444;
    step();
    bus_i_rvalid = 1'b0;
    chk("fl_new_valid", fetch_o_valid, 64'd1);
    chk("fl_new_rdata", fetch_o_rdata, 64'h4444);
    fetch_i_req = 1'b0;
    step();

    // Flush during REQ_IF with gnt low; stray rvalid afterwards is ignored
    fetch_i_req  = 1'b1;
    fetch_i_addr = 64'h5000;
    step();
    chk("fr_req", bus_o_req, 64'd1);
    fetch_i_flush = 1'b1;
    step();
    fetch_i_flush = 1'b0;
    fetch_i_req   = 1'b0;
    chk("fr_req_drop", bus_o_req, 64'd0);
    bus_i_rvalid = 1'b1;
    bus_i_rdata  = 64'h777;
    step();
    bus_i_rvalid = 1'b0;
    chk("fr_no_fvalid", fetch_o_valid, 64'd0);
    chk("fr_no_lvalid", lsu_o_valid, 64'd0);
    chk("fr_idle_req", bus_o_req, 64'd0);
    chk("fr_rdata_kept", fetch_o_rdata, 64'h4444);
    step();

    // Reset asserted mid WAIT_LSU
    lsu_i_req  = 1'b1;
    lsu_i_addr = 64'h6000;
    step();
    chk("rs_req", bus_o_req, 64'd1);
    bus_i_gnt = 1'b1;
    step();
    bus_i_gnt = 1'b0;
    chk("rs_wait_addr", bus_o_addr, 64'h6000);
    rst_n = 1'b0;
    #1;
    chk("rs_addr", bus_o_addr, 64'd0);
    chk("rs_req0", bus_o_req, 64'd0);
    chk("rs_wstrb", bus_o_wstrb, 64'd0);
    chk("rs_frdata", fetch_o_rdata, 64'd0);
    chk("rs_lrdata", lsu_o_rdata, 64'd0);
    chk("rs_lvalid", lsu_o_valid, 64'd0);
    lsu_i_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rs_after_req", bus_o_req, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
